// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//   IF/ID pipeline register plus MIPS field decoder. Sits on the consumer side
//   of the fetch-stage interface. Each cycle it captures PC, PC+4 and the
//   instruction word from fetch. It holds them while decode is stalled. After a
//   MEM-stage redirect it replaces wrong-path fetches with NOP bubbles.
//
//   Parameters
//     FLUSH_CYCLES  extra bubbles after the redirect cycle (0..7). These cover
//                   fetch registers that are still in flight.
//
//   Ports
//     Clk, Clrn         clock (rising edge); async reset, active low
//     IFout_PC/PC4/Inst fetch-stage PC, PC+4 and instruction word
//     MEM_PCSrc         redirect taken in MEM; squash request
//     ID_Stall          hazard unit asks decode to hold its contents
//     IF_Hold           freeze PC/fetch this cycle
//     ID_Valid          ID contents are a real instruction (0 = bubble)
//     ID_PC/PC4/Inst    registered fetch values (Inst = 0 for a bubble)
//     ID_Op..ID_Jaddr   combinational field slices of ID_Inst / ID_PC4
// -----------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [31:0] IFout_PC,
    input  logic [31:0] IFout_PC4,
    input  logic [31:0] IFout_Inst,
    input  logic        MEM_PCSrc,
    input  logic        ID_Stall,
    output logic        IF_Hold,
    output logic        ID_Valid,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC4,
    output logic [31:0] ID_Inst,
    output logic [5:0]  ID_Op,
    output logic [4:0]  ID_Rs,
    output logic [4:0]  ID_Rt,
    output logic [4:0]  ID_Rd,
    output logic [4:0]  ID_Shamt,
    output logic [5:0]  ID_Funct,
    output logic [31:0] ID_ImmS,
    output logic [31:0] ID_ImmZ,
    output logic [31:0] ID_Jaddr
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    logic [31:0] pc_q,   pc_d;
    logic [31:0] pc4_q,  pc4_d;
    logic [31:0] inst_q, inst_d;
    logic        vld_q,  vld_d;
    logic [2:0]  cnt_q,  cnt_d;

    logic        flushing;
    assign flushing = (cnt_q != 3'd0);

    // Next-state selection. A redirect outranks an ongoing flush, so a second
    // redirect restarts the bubble run. A flush in turn outranks a stall, so
    // bubbles keep advancing. During a bubble the PCs still track fetch so
    // that downstream PC-relative logic sees coherent values.
    always_comb begin
        pc_d   = pc_q;
        pc4_d  = pc4_q;
        inst_d = inst_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (MEM_PCSrc) begin
            pc_d   = IFout_PC;
            pc4_d  = IFout_PC4;
            inst_d = 32'h0;
            vld_d  = 1'b0;
            cnt_d  = FLUSH_INIT;
        end else if (flushing) begin
            pc_d   = IFout_PC;
            pc4_d  = IFout_PC4;
            inst_d = 32'h0;
            vld_d  = 1'b0;
            cnt_d  = cnt_q - 3'd1;
        end else if (!ID_Stall) begin
            pc_d   = IFout_PC;
            pc4_d  = IFout_PC4;
            inst_d = IFout_Inst;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q   <= 32'h0;
            pc4_q  <= 32'h0;
            inst_q <= 32'h0;
            vld_q  <= 1'b0;
            cnt_q  <= 3'd0;
        end else begin
            pc_q   <= pc_d;
            pc4_q  <= pc4_d;
            inst_q <= inst_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    // Fetch is frozen only when the stall really takes effect here. A redirect
    // or a flush in progress overrides it, and fetch must run to pick up the
    // target path. Gate with Clrn so that no hold leaks out while in reset.
    assign IF_Hold = Clrn & ID_Stall & ~MEM_PCSrc & ~flushing;

    assign ID_Valid = vld_q;
    assign ID_PC    = pc_q;
    assign ID_PC4   = pc4_q;
    assign ID_Inst  = inst_q;

    assign ID_Op    = inst_q[31:26];
    assign ID_Rs    = inst_q[25:21];
    assign ID_Rt    = inst_q[20:16];
    assign ID_Rd    = inst_q[15:11];
    assign ID_Shamt = inst_q[10:6];
    assign ID_Funct = inst_q[5:0];
    assign ID_ImmS  = {{16{inst_q[15]}}, inst_q[15:0]};
    assign ID_ImmZ  = {16'h0, inst_q[15:0]};
    assign ID_Jaddr = {pc4_q[31:28], inst_q[25:0], 2'b00};

endmodule
